bus_memory_responder: RTL and testbench



---
 rtl/bus_mem_pkg.sv | 14 +
 rtl/bus_memory_responder_array.sv | 33 +++
 rtl/bus_memory_responder.sv | 149 ++++++++++++++
 tb/tb_bus_memory_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the bus memory responder.
// Optional debug outputs are enabled with MEM_DEBUG_PORTS_EN.
package bus_mem_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int OFS_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        RELEASE
    } state_t;
endpackage

// File: rtl/bus_memory_responder_array.sv
// Doubleword storage: combinational read, synchronous write, no reset.
// MEM_DEBUG_PORTS_EN exposes the low halfwords of entries 0..7.
module mem_array_64
    import bus_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
`ifdef MEM_DEBUG_PORTS_EN
    output logic [7:0][15:0]      dbg_low,
`endif
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

`ifdef MEM_DEBUG_PORTS_EN
    for (genvar g = 0; g < 8; g++) begin : g_dbg
        assign dbg_low[g] = r_mem[g][15:0];
    end
`endif
endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side responder on the shared tristate data bus with wait states.
// Define MEM_DEBUG_PORTS_EN to add the m0..m7 visualization outputs.
module bus_memory_responder
    import bus_mem_pkg::*;
#(
    parameter int                DEPTH_LOG2  = 8,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              ready,
    output logic              error,
`ifdef MEM_DEBUG_PORTS_EN
    output logic [15:0]       m0,
    output logic [15:0]       m1,
    output logic [15:0]       m2,
    output logic [15:0]       m3,
    output logic [15:0]       m4,
    output logic [15:0]       m5,
    output logic [15:0]       m6,
    output logic [15:0]       m7,
`endif
    output logic              busy
);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_is_read;
    logic                  r_err;
    logic [DEPTH_LOG2-1:0] r_idx;

    logic [ADDR_W-1:0]     w_word;
    logic                  w_req;
    logic                  w_illegal;
    logic                  w_bad_addr;
    logic                  w_accept;
    logic                  w_we;
    logic [DATA_W-1:0]     w_rdata;

    assign w_req      = mem_read | mem_write;
    assign w_illegal  = mem_read & mem_write;
    assign w_word     = (addr - BASE_ADDR) >> OFS_W;
    assign w_bad_addr = (addr[OFS_W-1:0] != '0) ||
                        (addr < BASE_ADDR) ||
                        ((w_word >> DEPTH_LOG2) != '0);
    assign w_accept   = (r_state == IDLE) && w_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_read <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Address and direction are frozen at acceptance.
            if (w_accept) begin
                r_is_read <= mem_read;
                r_err     <= w_illegal | w_bad_addr;
                r_idx     <= w_word[DEPTH_LOG2-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ready       = 1'b0;
        error       = 1'b0;
        busy        = 1'b1;
        w_we        = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy      = 1'b0;
                w_cnt_nxt = '0;
                if (w_req) begin
                    if (w_illegal || WAIT_STATES == 0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (int'(r_cnt) >= WAIT_STATES - 1) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RESP: begin
                ready       = 1'b1;
                error       = r_err;
                w_we        = ~r_is_read & ~r_err;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Error reads drive zero rather than leaving the bus floating.
    assign data = (r_state == RESP && r_is_read) ?
                  (r_err ? '0 : w_rdata) : 'z;

`ifdef MEM_DEBUG_PORTS_EN
    logic [7:0][15:0] w_dbg;

    assign m0 = w_dbg[0];
    assign m1 = w_dbg[1];
    assign m2 = w_dbg[2];
    assign m3 = w_dbg[3];
    assign m4 = w_dbg[4];
    assign m5 = w_dbg[5];
    assign m6 = w_dbg[6];
    assign m7 = w_dbg[7];
`endif

    mem_array_64 #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
`ifdef MEM_DEBUG_PORTS_EN
        .dbg_low(w_dbg),
`endif
        .clock  (clock),
        .we     (w_we),
        .waddr  (r_idx),
        .wdata  (data),
        .raddr  (r_idx),
        .rdata  (w_rdata)
    );
endmodule

// File: tb/tb_bus_memory_responder.sv
// Self-checking bench for bus_memory_responder against a memory model.
// Define MEM_DEBUG_PORTS_EN to also exercise the m0..m7 outputs.
module tb_bus_memory_responder;
    localparam int          WS    = 2;
    localparam int          DL    = 8;
    localparam int          DEPTH = 1 << DL;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [63:0] FLOAT = {64{1'b1}};

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic        ready;
    logic        error;
    logic        busy;
    wire  [63:0] data;
    logic        drv_en;
    logic [63:0] drv;
`ifdef MEM_DEBUG_PORTS_EN
    logic [15:0] m0, m1, m2, m3, m4, m5, m6, m7;
`endif

    logic [63:0] model [DEPTH];
    bit          known [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign data = drv_en ? drv : 'z;

    // An undriven bus reads back as all ones.
    for (genvar g = 0; g < 64; g++) begin : g_pu
        pullup (data[g]);
    end

    always #5 clock = ~clock;

    bus_memory_responder #(
        .DEPTH_LOG2 (DL),
        .WAIT_STATES(WS),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .data     (data),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .ready    (ready),
        .error    (error),
`ifdef MEM_DEBUG_PORTS_EN
        .m0(m0), .m1(m1), .m2(m2), .m3(m3),
        .m4(m4), .m5(m5), .m6(m6), .m7(m7),
`endif
        .busy     (busy)
    );

    // One transaction: request held for at least hold cycles after accept.
    task automatic access(input bit rd, input bit wr,
                          input logic [31:0] a, input logic [63:0] wd,
                          input int hold, input string tag);
        bit          illegal;
        bit          exp_err;
        bit          exp_rdy;
        bit          data_ok;
        int          idx;
        int          lat;
        int          d;
        int          readies;
        logic [63:0] exp_data;
        illegal = rd && wr;
        exp_err = illegal || (a % 8 != 0) || (a < BASE) ||
                  ((a - BASE) / 8 >= DEPTH);
        idx     = exp_err ? 0 : int'((a - BASE) / 8);
        lat     = illegal ? 1 : WS + 1;
        d       = (hold > lat) ? hold : lat;
        readies = 0;
        data_ok = exp_err || known[idx];
        exp_data = exp_err ? 64'h0 : model[idx];
        @(negedge clock);
        addr      = a;
        mem_read  = rd;
        mem_write = wr;
        if (wr && !rd) begin
            drv_en = 1'b1;
            drv    = wd;
        end
        @(posedge clock);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            exp_rdy = (k == lat);
            if (ready) readies++;
            n_cmp++;
            if (ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL %s ready k=%0d: got %b want %b",
                         tag, k, ready, exp_rdy);
            end
            n_cmp++;
            if (error !== (exp_rdy && exp_err)) begin
                n_bad++;
                $display("FAIL %s error k=%0d: got %b want %b",
                         tag, k, error, exp_rdy && exp_err);
            end
            n_cmp++;
            if (busy !== (k <= d + 1)) begin
                n_bad++;
                $display("FAIL %s busy k=%0d: got %b want %b",
                         tag, k, busy, k <= d + 1);
            end
            if (!drv_en) begin
                if (exp_rdy && rd) begin
                    if (data_ok) begin
                        n_cmp++;
                        if (data !== exp_data) begin
                            n_bad++;
                            $display("FAIL %s rdata: got %h want %h",
                                     tag, data, exp_data);
                        end
                    end
                end else begin
                    n_cmp++;
                    if (data !== FLOAT) begin
                        n_bad++;
                        $display("FAIL %s bus k=%0d: got %h want z",
                                 tag, k, data);
                    end
                end
            end
            if (k == d) begin
                @(posedge clock);
                #1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                drv_en    = 1'b0;
                addr      = $urandom;
            end
            if (k == d + 2) break;
        end
        n_cmp++;
        if (readies != 1) begin
            n_bad++;
            $display("FAIL %s ready_count: got %0d want 1", tag, readies);
        end
        if (wr && !rd && !exp_err) begin
            model[idx] = wd;
            known[idx] = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({ready, error, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset outs: got %b want 000",
                     {ready, error, busy});
        end
        n_cmp++;
        if (data !== FLOAT) begin
            n_bad++;
            $display("FAIL reset bus: got %h want z", data);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        access(0, 1, 32'h10, 64'hDEAD_BEEF_0123_4567, 0, "wr10");
        access(1, 0, 32'h10, 64'h0, 0, "rd10");
    endtask

    task automatic test_bad_access();
        access(0, 1, 32'h13, 64'h1111_2222_3333_4444, 0, "wr_mis");
        access(0, 1, 32'h800, 64'h5555_6666_7777_8888, 0, "wr_oor");
        access(1, 0, 32'h10, 64'h0, 0, "rd10_after_bad");
        access(1, 0, 32'h0000_0805, 64'h0, 0, "rd_bad");
    endtask

    task automatic test_held_request();
        access(1, 0, 32'h10, 64'h0, 10, "held_rd");
    endtask

    task automatic test_illegal();
        access(1, 1, 32'h10, 64'h0, 0, "illegal");
        access(1, 0, 32'h10, 64'h0, 0, "rd10_after_illegal");
    endtask

    task automatic test_reset_mid_wait();
        access(0, 1, 32'h20, 64'hCAFE_F00D_0000_0020, 0, "wr20");
        @(negedge clock);
        addr      = 32'h20;
        mem_write = 1'b1;
        drv_en    = 1'b1;
        drv       = 64'h1;
        @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midwait busy_pre: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ready, error, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL midwait outs: got %b want 000",
                     {ready, error, busy});
        end
        mem_write = 1'b0;
        drv_en    = 1'b0;
        #1;
        n_cmp++;
        if (data !== FLOAT) begin
            n_bad++;
            $display("FAIL midwait bus: got %h want z", data);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        access(1, 0, 32'h20, 64'h0, 0, "rd20_after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [63:0] wd;
        int          sel;
        bit          rd;
        bit          wr;
        for (int i = 0; i < 16; i++) begin
            wd = {$urandom, $urandom};
            access(0, 1, BASE + 32'(i * 8), wd, $urandom_range(0, 4), "fill");
        end
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            wd  = {$urandom, $urandom};
            rd  = 1'b0;
            wr  = 1'b0;
            a   = BASE + 32'($urandom_range(0, 15) * 8);
            if (sel <= 3) begin
                wr = 1'b1;
            end else if (sel <= 6) begin
                rd = 1'b1;
            end else if (sel == 7) begin
                a  = a + 32'($urandom_range(1, 7));
                rd = $urandom_range(0, 1) == 1;
                wr = !rd;
            end else if (sel == 8) begin
                a  = BASE + 32'h800 + 32'($urandom_range(0, 255) * 8);
                rd = $urandom_range(0, 1) == 1;
                wr = !rd;
            end else begin
                rd = 1'b1;
                wr = 1'b1;
            end
            access(rd, wr, a, wd, $urandom_range(0, 5), "rand");
        end
        for (int i = 0; i < 16; i++) begin
            access(1, 0, BASE + 32'(i * 8), 64'h0, 0, "sweep");
        end
    endtask

`ifdef MEM_DEBUG_PORTS_EN
    task automatic test_debug_ports();
        access(0, 1, 32'h18, 64'h0000_0000_0000_ABCD, 0, "wr18");
        n_cmp++;
        if (m3 !== 16'hABCD) begin
            n_bad++;
            $display("FAIL m3: got %h want abcd", m3);
        end
        n_cmp++;
        if (m2 !== model[2][15:0]) begin
            n_bad++;
            $display("FAIL m2: got %h want %h", m2, model[2][15:0]);
        end
    endtask
`endif

    initial begin
        addr      = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        drv_en    = 1'b0;
        drv       = 64'h0;
        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 1'b0;
            model[i] = 64'h0;
        end
        test_reset();
        test_write_read();
        test_bad_access();
        test_held_request();
        test_illegal();
        test_reset_mid_wait();
        test_random();
`ifdef MEM_DEBUG_PORTS_EN
        test_debug_ports();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
